// File: rtl/disp_pkg.sv
// Shared glyphs, FSM state type and helpers for the multiplexed seven-segment driver.
// HEX_MODE_EN enables the A..F glyphs in seg_encode.
package disp_pkg;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
`ifdef HEX_MODE_EN
      4'd10:   g = SEG_A;
      4'd11:   g = SEG_B;
      4'd12:   g = SEG_C;
      4'd13:   g = SEG_D;
      4'd14:   g = SEG_E;
      4'd15:   g = SEG_F;
`endif
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/disp_mux_seg_n_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one shift/add-3 step per clock after i_start.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_bin,
  output logic                  o_done_c,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_adj;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  // Add 3 to every digit >= 5 before the shift; digits above DIGITS are dropped
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd  <= {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
      r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(DATA_W - 1)) r_busy <= 1'b0;
    end
  end

  assign o_done_c = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
  assign o_bcd    = r_bcd;

endmodule

// File: rtl/disp_mux_seg_n.sv
// disp_mux_seg_n: N-digit multiplexed seven-segment driver with valid/ready input and BCD conversion.
// Define HEX_MODE_EN to add the hex_mode input (direct nibble display, no conversion).
module disp_mux_seg_n
  import disp_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SCAN_HZ    = 1_000,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DATA_W     = 14,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              blank_lz,
`ifdef HEX_MODE_EN
  input  logic              hex_mode,
`endif
  output logic              ovf,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig
);

  localparam int unsigned SCAN_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int unsigned DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BCD_W    = 4 * DIGITS;
  localparam logic [63:0] OVF_LIM  = pow10(DIGITS);
  localparam logic [7:0]        SEG_XOR = ACTIVE_LOW ? 8'h00 : 8'hFF;
  localparam logic [DIGITS-1:0] DIG_XOR = ACTIVE_LOW ? '0 : '1;

  state_t            r_state, w_state_nx;
  logic              r_ready, w_accept, w_done_c;
  logic [DATA_W-1:0] r_bin;
  logic [DIGITS-1:0] r_dp;
  logic [BCD_W-1:0]  w_bcd, w_src;
  logic              w_ovf_nx, w_lead;
  logic [3:0]        w_nib;
  logic [7:0]        w_load_glyph [DIGITS];
  logic [7:0]        r_glyph [DIGITS];
  logic [7:0]        w_cur;
  logic [DIV_W-1:0]  r_div;
  logic [IDX_W-1:0]  r_idx;
  logic              w_tick;
  logic              r_ovf;
  logic [7:0]        r_seg;
  logic [DIGITS-1:0] r_dig;
`ifdef HEX_MODE_EN
  logic                    r_hex;
  logic [DATA_W+BCD_W-1:0] w_bin_ext;
  assign w_bin_ext = {{BCD_W{1'b0}}, r_bin};
`endif

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_bcd (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_bin    (in_data),
    .o_done_c (w_done_c),
    .o_bcd    (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_ready <= (w_state_nx == IDLE);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: if (in_valid) begin
        w_accept   = 1'b1;
        w_state_nx = CONV;
`ifdef HEX_MODE_EN
        if (hex_mode) w_state_nx = LOAD;
`endif
      end
      CONV:    if (w_done_c) w_state_nx = LOAD;
      LOAD:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_dp  <= '0;
`ifdef HEX_MODE_EN
      r_hex <= 1'b0;
`endif
    end else if (w_accept) begin
      r_bin <= in_data;
      r_dp  <= dp_in;
`ifdef HEX_MODE_EN
      r_hex <= hex_mode;
`endif
    end
  end

  // Digit source and overflow for the pending LOAD
  always_comb begin
    w_src    = w_bcd;
    w_ovf_nx = (64'(r_bin) >= OVF_LIM);
`ifdef HEX_MODE_EN
    if (r_hex) begin
      w_src    = w_bin_ext[BCD_W-1:0];
      w_ovf_nx = |w_bin_ext[DATA_W+BCD_W-1:BCD_W];
    end
`endif
  end

  // Walk from the top digit down; leading zeros stay blank until the first non-zero digit
  always_comb begin
    w_lead = 1'b1;
    w_nib  = 4'd0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_nib           = w_src[4*i +: 4];
      w_load_glyph[i] = seg_encode(w_nib);
      if (i != 0) begin
        w_lead = w_lead && (w_nib == 4'd0);
        if (blank_lz && w_lead) w_load_glyph[i] = SEG_BLANK;
      end
      if (w_ovf_nx)     w_load_glyph[i] = SEG_DASH;
      else if (r_dp[i]) w_load_glyph[i][7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DIGITS); i++) r_glyph[i] <= SEG_BLANK;
      r_ovf <= 1'b0;
    end else if (r_state == LOAD) begin
      for (int i = 0; i < int'(DIGITS); i++) r_glyph[i] <= w_load_glyph[i];
      r_ovf <= w_ovf_nx;
    end
  end

  // Bypass during LOAD so the new glyph reaches seg on the cycle after LOAD
  always_comb begin
    w_cur = (r_state == LOAD) ? w_load_glyph[r_idx] : r_glyph[r_idx];
  end

  assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
      r_seg <= SEG_BLANK ^ SEG_XOR;
      r_dig <= {DIGITS{1'b1}} ^ DIG_XOR;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      r_seg <= w_cur ^ SEG_XOR;
      r_dig <= ~(DIGITS'(1) << r_idx) ^ DIG_XOR;
    end
  end

  assign in_ready = r_ready;
  assign ovf      = r_ovf;
  assign seg      = r_seg;
  assign dig      = r_dig;

endmodule

// File: tb/tb_disp_mux_seg_n.sv
// Directed bench for disp_mux_seg_n with DIGITS=4, DATA_W=14, SCAN_DIV=4, active-low outputs.
module tb_disp_mux_seg_n;

  logic        clk;
  logic        rst;
  logic [13:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dp_in;
  logic        blank_lz;
`ifdef HEX_MODE_EN
  logic        hex_mode;
`endif
  logic        ovf;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int checks = 0;
  int errors = 0;

  disp_mux_seg_n #(
    .CLK_HZ(16_000), .SCAN_HZ(1_000), .DIGITS(4), .DATA_W(14), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
`ifdef HEX_MODE_EN
    .hex_mode (hex_mode),
`endif
    .ovf      (ovf),
    .seg      (seg),
    .dig      (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dig_index(input logic [3:0] d);
    case (d)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return 0;
    endcase
  endfunction

  // Offer a value and return one cycle after it is accepted (cycle T+1)
  task automatic send(input logic [13:0] v, input logic [3:0] dp, input logic blz);
    in_data  = v;
    dp_in    = dp;
    blank_lz = blz;
    in_valid = 1'b1;
    for (int n = 0; n < 40 && in_ready !== 1'b1; n++) tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40 && in_ready !== 1'b1; n++) tick();
    check("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic show(input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    logic [3:0] want;
    ex = '{e0, e1, e2, e3};
    for (int d = 0; d < 4; d++) begin
      want = ~(4'b0001 << d);
      for (int n = 0; n < 40 && dig !== want; n++) tick();
      check($sformatf("dig_sel%0d", d), 32'(dig), 32'(want));
      check($sformatf("seg_digit%0d", d), 32'(seg), 32'(ex[d]));
    end
  endtask

  initial begin
    logic [3:0] scan_exp [4];
    logic [7:0] ex1234 [4];
    scan_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
    ex1234   = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    rst = 1'b1; in_data = '0; in_valid = 1'b0; dp_in = '0; blank_lz = 1'b0;
`ifdef HEX_MODE_EN
    hex_mode = 1'b0;
`endif

    // Reset holds outputs inactive
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_dig", 32'(dig), 32'hF);
      check("rst_ready", 32'(in_ready), 32'd1);
    end
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Idle scan: each digit selected for 4 clocks, display blank
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("scan_dig%0d", k), 32'(dig), 32'(scan_exp[k/4]));
      check($sformatf("scan_seg%0d", k), 32'(seg), 32'hFF);
      tick();
    end

    // 1234, no blanking: busy T+1..T+15, visible at T+16
    send(14'd1234, 4'b0000, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("busy_T%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    check("ready_T16", 32'(in_ready), 32'd1);
    check("seg_T16", 32'(seg), 32'(ex1234[dig_index(dig)]));
    check("ovf_1234", 32'(ovf), 32'd0);
    show(8'h99, 8'hB0, 8'hA4, 8'hF9);

    // 7 with blanking and dp on digit 2
    send(14'd7, 4'b0100, 1'b1);
    wait_ready();
    show(8'hF8, 8'hFF, 8'h7F, 8'hFF);

    // Overflow then recovery
    send(14'd10000, 4'b0000, 1'b0);
    wait_ready();
    check("ovf_set", 32'(ovf), 32'd1);
    show(8'hBF, 8'hBF, 8'hBF, 8'hBF);
    send(14'd0, 4'b0000, 1'b1);
    wait_ready();
    check("ovf_clr", 32'(ovf), 32'd0);
    show(8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Boundary: 9999 is in range
    send(14'd9999, 4'b0000, 1'b0);
    wait_ready();
    check("ovf_9999", 32'(ovf), 32'd0);
    show(8'h90, 8'h90, 8'h90, 8'h90);

    // 42 held on in_valid while busy is accepted once
    send(14'd99, 4'b0000, 1'b1);
    in_data  = 14'd42;
    in_valid = 1'b1;
    check("held_busy", 32'(in_ready), 32'd0);
    for (int n = 0; n < 40 && in_ready !== 1'b1; n++) tick();
    tick();
    in_valid = 1'b0;
    check("held_accepted", 32'(in_ready), 32'd0);
    wait_ready();
    tick();
    check("held_single", 32'(in_ready), 32'd1);
    show(8'hA4, 8'h99, 8'hFF, 8'hFF);

    // Reset at T+5 aborts the conversion
    send(14'd1234, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("abort_busy_T5", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_seg", 32'(seg), 32'hFF);
    check("abort_dig", 32'(dig), 32'hF);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("abort_ready_hold", 32'(in_ready), 32'd1);
    show(8'hFF, 8'hFF, 8'hFF, 8'hFF);

`ifdef HEX_MODE_EN
    // Hex: LOAD at T+1, ready again at T+2
    hex_mode = 1'b1;
    send(14'h3AF, 4'b0000, 1'b0);
    check("hex_busy_T1", 32'(in_ready), 32'd0);
    tick();
    check("hex_ready_T2", 32'(in_ready), 32'd1);
    check("hex_ovf", 32'(ovf), 32'd0);
    hex_mode = 1'b0;
    show(8'h8E, 8'h88, 8'hB0, 8'hC0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
